// File: rtl/sdf_ctrl.sv
// Control for one radix-2 single-path delay-feedback FFT stage: sequences the
// FILL/FIRST/SECOND phases, flags protocol errors and supplies the twiddle.
module sdf_ctrl #(
  parameter int N_HALF = 8,
  parameter int DW     = 14,
  parameter int TW     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic                 inv_i,
  input  logic signed [DW-1:0] data_in_r,
  input  logic signed [DW-1:0] data_in_i,
  output logic signed [DW-1:0] data_out_r,
  output logic signed [DW-1:0] data_out_i,
  output logic [1:0]           state,
  output logic                 valid_o,
  output logic signed [TW-1:0] WN_r,
  output logic signed [TW-1:0] WN_i,
  output logic                 err_o
);

  localparam int CW  = $clog2(N_HALF);
  localparam int KSH = 5 - CW;   // step through the 32-entry half-circle table
  localparam int RSH = 18 - TW;  // Q16 table down to TW-2 fractional bits

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FIRST  = 2'b01,
    SECOND = 2'b10,
    FILL   = 2'b11
  } st_e;

  st_e                 r_state, w_state_nx;
  logic [CW-1:0]       r_cnt, w_cnt_nx;
  logic                r_nxt, w_nxt_nx;
  logic                r_inv_cur, w_inv_cur_nx;
  logic                r_inv_nxt, w_inv_nxt_nx;
  logic                r_valid_o, r_err, w_err_nx;
  logic signed [DW-1:0] r_dr, r_di;
  logic                w_last;

  // cos(pi*m/32) in Q16 for m = 0..16; other angles come from symmetry
  function automatic logic [16:0] cos_q16(input logic [4:0] m);
    case (m)
      5'd0:    return 17'd65536;
      5'd1:    return 17'd65220;
      5'd2:    return 17'd64277;
      5'd3:    return 17'd62714;
      5'd4:    return 17'd60547;
      5'd5:    return 17'd57798;
      5'd6:    return 17'd54491;
      5'd7:    return 17'd50660;
      5'd8:    return 17'd46341;
      5'd9:    return 17'd41576;
      5'd10:   return 17'd36410;
      5'd11:   return 17'd30893;
      5'd12:   return 17'd25080;
      5'd13:   return 17'd19024;
      5'd14:   return 17'd12785;
      5'd15:   return 17'd6424;
      default: return 17'd0;
    endcase
  endfunction

  // magnitudes are non-negative, so add-half-then-shift rounds ties away from zero
  function automatic logic signed [TW-1:0] to_tw(input logic [16:0] q, input logic neg);
    logic [17:0]          r;
    logic signed [TW-1:0] m;
    r = (18'(q) + (18'd1 << (RSH - 1))) >> RSH;
    m = r[TW-1:0];
    return neg ? -m : m;
  endfunction

  assign w_last = (r_cnt == CW'(N_HALF - 1));

  always_comb begin
    w_state_nx   = r_state;
    w_nxt_nx     = r_nxt;
    w_inv_cur_nx = r_inv_cur;
    w_inv_nxt_nx = r_inv_nxt;
    w_err_nx     = 1'b0;
    case (r_state)
      IDLE: if (valid_i) begin
        w_state_nx   = FILL;
        w_inv_cur_nx = inv_i;
      end
      FILL: begin
        if (!valid_i) begin
          w_state_nx = IDLE;
          w_err_nx   = 1'b1;
          w_nxt_nx   = 1'b0;
        end else if (w_last) w_state_nx = FIRST;
      end
      FIRST: begin
        if (!w_last && !valid_i) begin
          w_state_nx = IDLE;
          w_err_nx   = 1'b1;
          w_nxt_nx   = 1'b0;
        end else if (w_last) begin
          w_state_nx = SECOND;
          if (valid_i) begin
            w_nxt_nx     = 1'b1;
            w_inv_nxt_nx = inv_i;
          end
        end
      end
      SECOND: begin
        if (r_nxt && !valid_i) begin
          w_state_nx = IDLE;
          w_err_nx   = 1'b1;
          w_nxt_nx   = 1'b0;
        end else begin
          if (!r_nxt && valid_i) w_err_nx = 1'b1;
          if (w_last) begin
            if (r_nxt) begin
              w_state_nx   = FIRST;
              w_inv_cur_nx = r_inv_nxt;
              w_nxt_nx     = 1'b0;
            end else w_state_nx = IDLE;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
    if (w_state_nx != r_state || r_state == IDLE) w_cnt_nx = '0;
    else                                          w_cnt_nx = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_nxt     <= 1'b0;
      r_inv_cur <= 1'b0;
      r_inv_nxt <= 1'b0;
      r_valid_o <= 1'b0;
      r_err     <= 1'b0;
      r_dr      <= '0;
      r_di      <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_nxt     <= w_nxt_nx;
      r_inv_cur <= w_inv_cur_nx;
      r_inv_nxt <= w_inv_nxt_nx;
      r_valid_o <= (w_state_nx == FIRST) || (w_state_nx == SECOND);
      r_err     <= w_err_nx;
      r_dr      <= data_in_r;
      r_di      <= data_in_i;
    end
  end

  // twiddle angle pi*cnt/N_HALF maps to index k = cnt*32/N_HALF of a 32-step half circle
  logic [4:0] w_k, w_kc, w_ks;
  assign w_k  = 5'(r_cnt) << KSH;
  assign w_kc = (w_k <= 5'd16) ? w_k : 5'(6'd32 - 6'(w_k));
  assign w_ks = (w_k >= 5'd16) ? (w_k - 5'd16) : (5'd16 - w_k);

  always_comb begin
    WN_r = '0;
    WN_i = '0;
    if (r_state == SECOND) begin
      WN_r = to_tw(cos_q16(w_kc), w_k > 5'd16);
      WN_i = to_tw(cos_q16(w_ks), !r_inv_cur);
    end
  end

  assign data_out_r = r_dr;
  assign data_out_i = r_di;
  assign state      = r_state;
  assign valid_o    = r_valid_o;
  assign err_o      = r_err;

endmodule

// File: tb/tb_sdf_ctrl.sv
// Bench for sdf_ctrl: spec-timing tables, corner sequences and a random run
// against a frame-age reference model.
module tb_sdf_ctrl;
  localparam int N  = 8;
  localparam int DW = 14;
  localparam int TW = 8;
  localparam int S_IDLE = 0, S_FIRST = 1, S_SECOND = 2, S_FILL = 3;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_i = 1'b0, inv_i = 1'b0, v4 = 1'b0;
  logic signed [DW-1:0] dr = '0, di = '0;
  logic signed [DW-1:0] dor, doi, d4r, d4i;
  logic [1:0] st, st4;
  logic vo, er, vo4, er4;
  logic signed [TW-1:0] wr, wi, w4r, w4i;

  sdf_ctrl #(.N_HALF(N), .DW(DW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .inv_i(inv_i),
    .data_in_r(dr), .data_in_i(di), .data_out_r(dor), .data_out_i(doi),
    .state(st), .valid_o(vo), .WN_r(wr), .WN_i(wi), .err_o(er));

  sdf_ctrl #(.N_HALF(4), .DW(DW), .TW(TW)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_i(v4), .inv_i(1'b0),
    .data_in_r(dr), .data_in_i(di), .data_out_r(d4r), .data_out_i(d4i),
    .state(st4), .valid_o(vo4), .WN_r(w4r), .WN_i(w4i), .err_o(er4));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference: each live frame is tracked by its age in cycles since sample 0.
  typedef struct { int age; bit inv; } frm_t;
  frm_t fq[$];
  int   m_err = 0;
  logic signed [DW-1:0] exp_dr = '0, exp_di = '0;

  function automatic int rnd(input real x);
    return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
  endfunction

  task automatic model_step(input logic v, input logic inv);
    bit need, start;
    need = 0;
    for (int k = 0; k < fq.size(); k++)
      if (fq[k].age >= 1 && fq[k].age <= 2*N-1) need = 1;
    m_err = 0;
    if (need && !v) begin
      fq.delete();
      m_err = 1;
    end else begin
      start = v && (fq.size() == 0 || (fq.size() == 1 && fq[0].age == 2*N));
      if (v && !start && !need) m_err = 1;
      for (int k = 0; k < fq.size(); k++) fq[k].age++;
      if (fq.size() > 0 && fq[0].age > 3*N) void'(fq.pop_front());
      if (start) fq.push_back('{age: 1, inv: inv});
    end
  endtask

  task automatic check_model();
    int ms, ewr, ewi, a, c;
    ms = S_IDLE; ewr = 0; ewi = 0;
    if (fq.size() > 0) begin
      a = fq[0].age;
      if (a >= 2*N+1) begin
        ms  = S_SECOND;
        c   = a - 2*N - 1;
        ewr = rnd(64.0 * $cos(PI * c / N));
        ewi = (fq[0].inv ? 1 : -1) * rnd(64.0 * $sin(PI * c / N));
      end else if (a >= N+1) ms = S_FIRST;
      else                   ms = S_FILL;
    end
    chk("m_state", int'(st), ms);
    chk("m_valid_o", int'(vo), int'(ms == S_FIRST || ms == S_SECOND));
    chk("m_err_o", int'(er), m_err);
    chk("m_dout_r", int'(dor), int'(exp_dr));
    chk("m_dout_i", int'(doi), int'(exp_di));
    chk("m_wn_r", int'(wr), ewr);
    chk("m_wn_i", int'(wi), ewi);
  endtask

  // One cycle: drive at the falling edge, clock, check at the next falling edge.
  task automatic tick(input logic v, input logic inv);
    valid_i = v;
    inv_i   = inv;
    dr = DW'($urandom);
    di = DW'($urandom);
    @(posedge clk);
    model_step(v, inv);
    exp_dr = dr;
    exp_di = di;
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic v; int st; logic vo; logic chk_wn; int wr; int wi;
  } vec_t;
  vec_t tbl[30];

  task automatic run_table(input logic inv);
    for (int i = 0; i < 30; i++) begin
      tick(tbl[i].v, (i == 0) ? inv : 1'b0);
      chk("t_state", int'(st), tbl[i].st);
      chk("t_valid_o", int'(vo), int'(tbl[i].vo));
      chk("t_err_o", int'(er), 0);
      if (tbl[i].chk_wn) begin
        chk("t_wn_r", int'(wr), tbl[i].wr);
        chk("t_wn_i", int'(wi), inv ? -tbl[i].wi : tbl[i].wi);
      end
    end
  endtask

  initial begin
    // entry i is the cycle driving sample i; its checks see cycle t0+i+1
    for (int i = 0; i < 30; i++) begin
      int j;
      j = i + 1;
      tbl[i].v  = (i < 16);
      tbl[i].st = (j <= 8) ? S_FILL : (j <= 16) ? S_FIRST : (j <= 24) ? S_SECOND : S_IDLE;
      tbl[i].vo = (tbl[i].st == S_FIRST || tbl[i].st == S_SECOND);
      tbl[i].chk_wn = 1'b1; tbl[i].wr = 0; tbl[i].wi = 0;
      if (tbl[i].st == S_SECOND)
        case (j - 17)
          0: begin tbl[i].wr = 64;  tbl[i].wi = 0;   end
          2: begin tbl[i].wr = 45;  tbl[i].wi = -45; end
          4: begin tbl[i].wr = 0;   tbl[i].wi = -64; end
          6: begin tbl[i].wr = -45; tbl[i].wi = -45; end
          7: begin tbl[i].wr = -59; tbl[i].wi = -24; end
          default: tbl[i].chk_wn = 1'b0;
        endcase
    end

    repeat (2) @(negedge clk);
    chk("rst_state", int'(st), S_IDLE);
    chk("rst_valid_o", int'(vo), 0);
    chk("rst_err_o", int'(er), 0);
    chk("rst_wn_r", int'(wr), 0);
    chk("rst_dout_r", int'(dor), 0);
    rst_n = 1'b1;

    run_table(1'b0);
    run_table(1'b1);

    // three back-to-back frames, conjugate only on the middle one
    for (int i = 0; i < 60; i++) begin
      int j;
      tick(i < 48, i == 16);
      j = i + 1;
      chk("bb_valid_o", int'(vo), int'(j >= 9 && j <= 56));
      if (j == 19) chk("bb_wn_i_f1", int'(wi), -45);
      if (j == 35) chk("bb_wn_i_f2", int'(wi), 45);
      if (j == 51) chk("bb_wn_i_f3", int'(wi), -45);
    end

    // valid dropped inside FILL
    for (int i = 0; i < 8; i++) begin
      tick(i < 5, 1'b0);
      if (i == 5) begin
        chk("drop_err", int'(er), 1);
        chk("drop_state", int'(st), S_IDLE);
        chk("drop_valid_o", int'(vo), 0);
      end
      if (i == 6) chk("drop_err_clr", int'(er), 0);
    end

    // asynchronous reset in the middle of SECOND, then a fresh frame
    for (int i = 0; i < 20; i++) tick(i < 16, 1'b0);
    chk("ar_pre_state", int'(st), S_SECOND);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", int'(st), S_IDLE);
    chk("ar_valid_o", int'(vo), 0);
    chk("ar_err_o", int'(er), 0);
    chk("ar_wn_r", int'(wr), 0);
    chk("ar_wn_i", int'(wi), 0);
    chk("ar_dout_r", int'(dor), 0);
    chk("ar_dout_i", int'(doi), 0);
    fq.delete(); m_err = 0; exp_dr = '0; exp_di = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_table(1'b0);

    // N_HALF=4 instance
    for (int i = 0; i < 14; i++) begin
      int j, es;
      v4 = (i < 8);
      tick(1'b0, 1'b0);
      j  = i + 1;
      es = (j <= 4) ? S_FILL : (j <= 8) ? S_FIRST : (j <= 12) ? S_SECOND : S_IDLE;
      chk("n4_state", int'(st4), es);
      chk("n4_valid_o", int'(vo4), int'(es == S_FIRST || es == S_SECOND));
      chk("n4_err_o", int'(er4), 0);
      chk("n4_dout_r", int'(d4r), int'(exp_dr));
      chk("n4_dout_i", int'(d4i), int'(exp_di));
      case (j)
        9:  begin chk("n4_wn_r0", int'(w4r), 64);  chk("n4_wn_i0", int'(w4i), 0);   end
        10: begin chk("n4_wn_r1", int'(w4r), 45);  chk("n4_wn_i1", int'(w4i), -45); end
        11: begin chk("n4_wn_r2", int'(w4r), 0);   chk("n4_wn_i2", int'(w4i), -64); end
        12: begin chk("n4_wn_r3", int'(w4r), -45); chk("n4_wn_i3", int'(w4i), -45); end
        default: begin chk("n4_wn_r", int'(w4r), 0); chk("n4_wn_i", int'(w4i), 0); end
      endcase
    end
    v4 = 1'b0;

    // random traffic against the frame-age model
    for (int i = 0; i < 900; i++) begin
      int pct;
      pct = (i < 450) ? 97 : 85;
      tick($urandom_range(0, 99) < pct, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
